fsquare: RTL and testbench

FSQUARE -- requirements
Module: fsquare

---
 rtl/fsquare.sv | 118 +++++++++++
 tb/tb_fsquare.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsquare.sv
// fsquare: 3-stage pipelined squarer for 15-bit floats
// (2b exception, sign, 6b exp bias 31, 6b fraction).
module fsquare #(
  parameter int ID = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] X,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [14:0] R,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [1:0] EXC_ZERO = 2'b00;
  localparam logic [1:0] EXC_NORM = 2'b01;
  localparam logic [1:0] EXC_INF  = 2'b10;
  localparam logic [1:0] EXC_NAN  = 2'b11;

  typedef struct packed {
    logic       v;
    logic [1:0] exc;
    logic [5:0] e;
    logic [5:0] f;
  } s1_t;

  typedef struct packed {
    logic        v;
    logic [1:0]  exc;
    logic [5:0]  e;
    logic [13:0] p;
  } s2_t;

  s1_t         s1_q;
  s2_t         s2_q;
  logic        advance;
  logic        c;
  logic [13:0] pn;
  logic        g;
  logic        st;
  logic        rup;
  logic [6:0]  sum;
  logic        rc;
  logic [7:0]  er;
  logic [14:0] r_next;
  logic        unused_bits;

  // Whole pipe moves as one; output slot free or draining.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Sign is dropped (square is never negative); ID is a tag.
  assign unused_bits = ^{X[12], pn[13:12], 32'(ID)};

  // S1: unpack operand fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
    end else if (advance) begin
      s1_q.v   <= in_valid;
      s1_q.exc <= X[14:13];
      s1_q.e   <= X[11:6];
      s1_q.f   <= X[5:0];
    end
  end

  // S2: 7x7 product of the implicit-one mantissa.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_q <= '0;
    end else if (advance) begin
      s2_q.v   <= s1_q.v;
      s2_q.exc <= s1_q.exc;
      s2_q.e   <= s1_q.e;
      s2_q.p   <= 14'({1'b1, s1_q.f}) * 14'({1'b1, s1_q.f});
    end
  end

  // S3 comb: normalize, round to nearest even, range check, pack.
  always_comb begin
    r_next = '0;
    c      = s2_q.p[13];
    pn     = c ? {1'b0, s2_q.p[13:1]} : s2_q.p;
    g      = pn[5];
    st     = (|pn[4:0]) || (c && s2_q.p[0]);
    rup    = g && (st || pn[6]);
    sum    = {1'b0, pn[11:6]} + 7'(rup);
    rc     = sum[6];
    er     = {1'b0, s2_q.e, 1'b0} - 8'd31 + 8'(c) + 8'(rc);
    unique case (s2_q.exc)
      EXC_ZERO: r_next = '0;
      EXC_INF:  r_next = 15'h4000;
      EXC_NAN:  r_next = 15'h6000;
      EXC_NORM: begin
        if (er[7])
          r_next = '0;
        else if (er[6])
          r_next = 15'h4000;
        else
          r_next = {EXC_NORM, 1'b0, er[5:0], sum[5:0]};
      end
    endcase
  end

  // S3: registered result and its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      R         <= '0;
    end else if (advance) begin
      out_valid <= s2_q.v;
      if (s2_q.v)
        R <= r_next;
    end
  end

endmodule

// File: tb/tb_fsquare.sv
// tb_fsquare: random and directed checks of fsquare
// against an integer-arithmetic reference of the float square.
module tb_fsquare;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] X;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] R;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  fsquare #(.ID(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Square of (1+F/64)*2^(E-31) with exact integers.
  function automatic logic [14:0] ref_sq(input logic [14:0] x);
    int e, f, m, q, sh, mant, rem, half, er;
    if (x[14:13] == 2'b00) return 15'h0000;
    if (x[14:13] == 2'b10) return 15'h4000;
    if (x[14:13] == 2'b11) return 15'h6000;
    e = int'(x[11:6]);
    f = int'(x[5:0]);
    m = 64 + f;
    q = m * m;
    sh = (q >= 8192) ? 7 : 6;
    mant = q >> sh;
    rem = q - (mant << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (mant % 2) == 1))
      mant++;
    er = 2 * e - 31 + (sh - 6);
    if (mant == 128) begin
      mant = 64;
      er++;
    end
    if (er > 63) return 15'h4000;
    if (er < 0) return 15'h0000;
    return {2'b01, 1'b0, er[5:0], mant[5:0]};
  endfunction

  function automatic logic [14:0] rand_x();
    logic [1:0] exc;
    logic [5:0] e;
    int r;
    r = $urandom_range(0, 15);
    exc = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 :
          (r == 2) ? 2'b11 : 2'b01;
    if ($urandom_range(0, 1) == 1)
      e = 6'($urandom_range(0, 63));
    else
      e = 6'($urandom_range(10, 50));
    return {exc, 1'($urandom), e, 6'($urandom)};
  endfunction

  // Scoreboard: push on accept, pop and compare on delivery.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("rdy", 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("sb", 32'(R), 32'(exp_q.pop_front()));
          pops++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sq(X));
        pushes++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [14:0] x, input logic [14:0] exp,
                         input string tag);
    int n;
    in_valid  = 1'b1;
    X         = x;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    X        = 15'($urandom);
    n        = 1;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, 32'(R), 32'(exp));
    step();
  endtask

  logic [14:0] ops [6];

  initial begin
    int i, cyc, p0, pu0, n;
    ops = '{15'h27C0, 15'h2800, 15'h27E0,
            15'h3820, 15'h27C1, 15'h2C00};

    // Reset with in_valid asserted: must be ignored.
    rst       = 1'b1;
    in_valid  = 1'b1;
    X         = 15'h27C0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_R", 32'(R), 0);
    chk("rst_rdy", 32'(in_ready), 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (5) begin
      step();
      chk("post_rst_ov", 32'(out_valid), 0);
    end

    // Directed values.
    run_one(15'h27C0, 15'h27C0, "one");
    run_one(15'h2800, 15'h2840, "two");
    run_one(15'h27E0, 15'h2808, "onep5");
    run_one(15'h3820, 15'h2888, "neg3");
    run_one(15'h27C1, 15'h27C2, "tie");
    run_one(15'h0000, 15'h0000, "zero");
    run_one(15'h5000, 15'h4000, "ninf");
    run_one(15'h7ABC, 15'h6000, "nan");
    run_one(15'h2C00, 15'h4000, "ovf");
    run_one(15'h2380, 15'h0000, "unf");

    // Backpressure: 6 back-to-back, stall 4 cycles mid-stream.
    i   = 0;
    cyc = 0;
    p0  = pops;
    while ((i < 6 || exp_q.size() != 0 || out_valid) && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 8);
      in_valid  = (i < 6);
      X         = ops[(i < 6) ? i : 0];
      @(negedge clk);
      if (cyc >= 4 && cyc < 8) begin
        chk("bp_rdy", 32'(in_ready), 0);
        chk("bp_ov", 32'(out_valid), 1);
        if (exp_q.size() != 0)
          chk("bp_hold", 32'(R), 32'(exp_q[0]));
      end
      if (in_valid && in_ready)
        i++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_timeout", 32'(cyc < 60), 1);
    chk("bp_cnt", pops - p0, 6);

    // Reset mid-operation discards in-flight operands.
    in_valid = 1'b1;
    X        = 15'h2800;
    step();
    X = 15'h27E0;
    step();
    X   = 15'h2840;
    rst = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("mr_ov", 32'(out_valid), 0);
    chk("mr_R", 32'(R), 0);
    p0 = pops;
    repeat (5) begin
      step();
      chk("mr_idle", 32'(out_valid), 0);
    end
    chk("mr_nopop", pops - p0, 0);
    run_one(15'h27C0, 15'h27C0, "mr_next");

    // Random traffic with random backpressure.
    cyc = 0;
    p0  = pops;
    pu0 = pushes;
    while (pushes - pu0 < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      X         = rand_x();
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      step();
      n++;
    end
    chk("rnd_acc", pushes - pu0, 10000);
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_pops", pops - p0, 10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
